// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC generation, imem requests, prefetch FIFO and registered ibus; define IFETCH_BRANCH_EN for branch redirect/flush
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_WORD   = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] iaddrbus,
  output logic        imem_req,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        stall,
  output logic [31:0] ibus,
  output logic        ibus_valid,
  output logic [31:0] pc_out
`ifdef IFETCH_BRANCH_EN
  ,
  input  logic        br_taken,
  input  logic [31:0] br_target
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
`ifdef IFETCH_BRANCH_EN
  typedef enum logic [1:0] {REQ, FULL, DRAIN} state_t;
`else
  typedef enum logic [1:0] {REQ, FULL} state_t;
`endif
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, ibus_q, ibus_d, pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic [31:0] fdat_q [FIFO_DEPTH];
  logic [31:0] fdat_d [FIFO_DEPTH];
  logic [31:0] fpc_q [FIFO_DEPTH];
  logic [31:0] fpc_d [FIFO_DEPTH];
  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic ack, bypass, pop, push;
`ifdef IFETCH_BRANCH_EN
  logic [31:0] drain_addr_q, drain_addr_d;
  assign iaddrbus = (state_q == DRAIN) ? drain_addr_q : pc_q;
  assign ack      = imem_ack && imem_req && state_q != DRAIN;
`else
  assign iaddrbus = pc_q;
  assign ack      = imem_ack && imem_req;
`endif
  assign imem_req   = !reset && state_q != FULL;
  assign ibus       = ibus_q;
  assign ibus_valid = valid_q;
  assign pc_out     = pc_out_q;
  // FIFO push/pop with bypass into the output register, PC advance and request FSM
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ibus_d   = ibus_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    fdat_d   = fdat_q;
    fpc_d    = fpc_q;
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    bypass   = !stall && count_q == '0 && ack;
    pop      = !stall && count_q != '0;
    push     = ack && !bypass;
    if (push) begin
      fdat_d[wptr_q] = imem_rdata;
      fpc_d[wptr_q]  = pc_q;
      wptr_d         = wptr_q + PW'(1);
    end
    if (pop) begin
      ibus_d   = fdat_q[rptr_q];
      pc_out_d = fpc_q[rptr_q];
      valid_d  = 1'b1;
      rptr_d   = rptr_q + PW'(1);
    end else if (bypass) begin
      ibus_d   = imem_rdata;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
    end else if (!stall) begin
      ibus_d  = NOP_WORD;
      valid_d = 1'b0;
    end
    count_d = count_q + CW'(push) - CW'(pop);
    pc_d    = ack ? pc_q + 32'd4 : pc_q;
    state_d = (state_q == REQ && ack && count_d == DEPTH_C) ? FULL :
              (state_q == FULL && pop) ? REQ : state_q;
`ifdef IFETCH_BRANCH_EN
    drain_addr_d = drain_addr_q;
    if (state_q == DRAIN && imem_ack) state_d = REQ;
    if (br_taken) begin
      count_d      = '0;
      rptr_d       = '0;
      wptr_d       = '0;
      pc_d         = {br_target[31:2], 2'b00};
      ibus_d       = NOP_WORD;
      valid_d      = 1'b0;
      state_d      = (imem_req && !imem_ack) ? DRAIN : REQ;
      drain_addr_d = (state_q == DRAIN) ? drain_addr_q : pc_q;
    end
`endif
  end
  // state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      ibus_q   <= NOP_WORD;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      count_q  <= '0;
      fdat_q   <= '{default: '0};
      fpc_q    <= '{default: '0};
`ifdef IFETCH_BRANCH_EN
      drain_addr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ibus_q   <= ibus_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      count_q  <= count_d;
      fdat_q   <= fdat_d;
      fpc_q    <= fpc_d;
`ifdef IFETCH_BRANCH_EN
      drain_addr_q <= drain_addr_d;
`endif
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit (branch test when IFETCH_BRANCH_EN is defined)
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000000;
  localparam logic [31:0] WRAP_PC = 32'hFFFFFFF8;
  logic clk = 1'b0, reset = 1'b1, imem_ack = 1'b0, stall = 1'b0;
  logic [31:0] iaddrbus, imem_rdata, ibus, pc_out;
  logic imem_req, ibus_valid;
  logic [31:0] w_addr, w_rdata, w_ibus, w_pc_out;
  logic w_req, w_valid;
  logic w_ack = 1'b1, w_stall = 1'b0;
  int tests = 0, fails = 0;
  typedef struct packed { logic [31:0] pc; logic [31:0] word; } ent_t;
  ent_t q[$];
  ent_t e;
  logic [31:0] exp_addr, prev_ibus, prev_pc;
  logic prev_v, ev;
`ifdef IFETCH_BRANCH_EN
  logic br_taken = 1'b0;
  logic [31:0] br_target = '0;
`endif
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h0C000000 + (a >> 2);
  endfunction
  assign imem_rdata = rom(iaddrbus);
  assign w_rdata    = rom(w_addr);
  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .iaddrbus(iaddrbus), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .stall(stall), .ibus(ibus),
    .ibus_valid(ibus_valid), .pc_out(pc_out)
`ifdef IFETCH_BRANCH_EN
    , .br_taken(br_taken), .br_target(br_target)
`endif
  );
  instr_fetch_unit #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(DEPTH), .NOP_WORD(NOP)) u_w (
    .clk(clk), .reset(reset), .iaddrbus(w_addr), .imem_req(w_req),
    .imem_rdata(w_rdata), .imem_ack(w_ack), .stall(w_stall), .ibus(w_ibus),
    .ibus_valid(w_valid), .pc_out(w_pc_out)
`ifdef IFETCH_BRANCH_EN
    , .br_taken(1'b0), .br_target(32'h0)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    imem_ack = 1'b1;
    stall = 1'b0;
    @(posedge clk); #1;
    chk("req_in_reset", 32'(imem_req), 32'd0);
    reset = 1'b0;
    q.delete();
    exp_addr = 32'h0; prev_ibus = NOP; prev_pc = 32'h0; prev_v = 1'b0;
    chk("rst_addr", iaddrbus, 32'h0);
    chk("rst_valid", 32'(ibus_valid), 32'd0);
    chk("rst_ibus", ibus, NOP);
    chk("rst_pc_out", pc_out, 32'h0);
  endtask
  task automatic cyc(input logic a, input logic s);
    imem_ack = a;
    stall = s;
    #1;
    chk("imem_req", 32'(imem_req), 32'(q.size() < DEPTH));
    if (imem_req) chk("iaddrbus", iaddrbus, exp_addr);
    if (imem_req && a) begin
      q.push_back({exp_addr, rom(exp_addr)});
      exp_addr += 32'd4;
    end
    ev = !s && q.size() > 0;
    if (ev) e = q.pop_front();
    @(posedge clk); #1;
    if (s) begin
      chk("hold_valid", 32'(ibus_valid), 32'(prev_v));
      chk("hold_ibus", ibus, prev_ibus);
      chk("hold_pc", pc_out, prev_pc);
    end else if (ev) begin
      chk("valid", 32'(ibus_valid), 32'd1);
      chk("ibus", ibus, e.word);
      chk("pc_out", pc_out, e.pc);
      prev_v = 1'b1; prev_ibus = e.word; prev_pc = e.pc;
    end else begin
      chk("bubble_valid", 32'(ibus_valid), 32'd0);
      chk("bubble_ibus", ibus, NOP);
      chk("bubble_pc", pc_out, prev_pc);
      prev_v = 1'b0; prev_ibus = NOP;
    end
  endtask
  initial begin
    do_reset();
    chk("wrap_rst_addr", w_addr, WRAP_PC);
    for (int i = 0; i < 8; i++) begin
      if (i < 4) chk("wrap_addr", w_addr, WRAP_PC + 32'(4 * i));
      cyc(1'b1, 1'b0);
      if (i < 4) begin
        chk("wrap_pc_out", w_pc_out, WRAP_PC + 32'(4 * i));
        chk("wrap_valid", 32'(w_valid), 32'd1);
      end
    end
    for (int i = 0; i < 12; i++) cyc(i % 3 == 2, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    reset = 1'b1;
    imem_ack = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    exp_addr = 32'h0; prev_ibus = NOP; prev_pc = 32'h0; prev_v = 1'b0;
    chk("midack_addr", iaddrbus, 32'h0);
    chk("midack_valid", 32'(ibus_valid), 32'd0);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
    chk("stall_start_pc", pc_out, 32'h8);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
    chk("full_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0);
    chk("resume_pc_out", pc_out, 32'h20);
`ifdef IFETCH_BRANCH_EN
    do_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    imem_ack = 1'b0; stall = 1'b1; br_taken = 1'b1; br_target = 32'h00000103;
    @(posedge clk); #1;
    br_taken = 1'b0;
    chk("br_valid", 32'(ibus_valid), 32'd0);
    chk("br_ibus", ibus, NOP);
    chk("drain_req", 32'(imem_req), 32'd1);
    chk("drain_addr", iaddrbus, 32'h8);
    imem_ack = 1'b1;
    @(posedge clk); #1;
    chk("br_fetch_addr", iaddrbus, 32'h100);
    chk("br_discard_valid", 32'(ibus_valid), 32'd0);
    stall = 1'b0;
    @(posedge clk); #1;
    chk("br_pc_out", pc_out, 32'h100);
    chk("br_word", ibus, rom(32'h100));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
